frag_div_unit: RTL
==================

// Module: frag_div_unit
// PURPOSE
//  Multi-cycle iterative integer divider for RV32M/RV64M DIV/DIVU/REM/REMU.
//  Consumes the 4-bit ALU_ctrl divide codes (1100..1111) from the ALU control decoder.
//  Sits beside the single-cycle ALU in EX. Stalls issue via in_ready; writeback via out_valid/out_ready.
// PARAMETERS
//  XLEN          32  operand/result width (>=8, even)
//  TAG_W          5  width of opaque tag (dest reg idx) carried input->output
//  FAST_SPECIAL   1  1: div-by-zero/overflow resolve without iterating; 0: iterate anyway
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       request valid
//  in_ready   out  1       unit can accept (high only in IDLE)
//  in_ctrl    in   4       1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU
//  in_a       in   XLEN    dividend
//  in_b       in   XLEN    divisor
//  in_tag     in   TAG_W   passed through unchanged
//  flush      in   1       synchronous abort of in-flight op
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  out_data   out  XLEN    quotient (DIV/DIVU) or remainder (REM/REMU)
//  out_tag    out  TAG_W   tag of the completed op
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; in_ready=1, out_valid=0, busy=0, out_data=0, out_tag=0.
//  Handshakes: accept on edge with in_valid&&in_ready; retire on edge with out_valid&&out_ready.
//   in_ready is combinational from state only (no in_valid->in_ready path). out_* hold stable
//   while out_valid&&!out_ready.
//  FSM: IDLE -> CALC (accept, normal) | DONE (accept, special & FAST_SPECIAL).
//   CALC -> CALC while count!=0; CALC -> FIX when last step done. FIX -> DONE.
//   DONE -> IDLE on out_ready. No accept in DONE, even when out_ready.
//  Accept edge: latch ctrl, tag, sign flags; load |a|,|b| (signed ops), raw a,b (unsigned ops).
//   Set count=XLEN-1; clear partial remainder.
//  CALC: one restoring step per cycle. rem' = {rem,q_msb} - b. If non-negative, keep it and set q bit.
//  FIX: quotient negated iff signed && sign(a)!=sign(b). Remainder takes the sign of a.
//   Select quotient/remainder per ctrl into out_data.
//  Latency: normal op gives out_valid in the cycle following edge XLEN+1 after accept (XLEN=32: 33).
//   Special with FAST_SPECIAL=1 gives out_valid the cycle after the accept edge.
//  Special cases (RISC-V spec):
//   b==0: quotient = all ones (both signednesses); remainder = a.
//   signed a==MIN_INT && b==-1: quotient = MIN_INT; remainder = 0.
//   With FAST_SPECIAL=0, the iterative path yields identical values (FIX enforces them).
//  flush: any state -> IDLE next edge. out_valid drops, no result delivered.
//   flush has priority over accept and retire in the same cycle.
//  Reset mid-op: immediate abort to reset values; the next op after deassert runs normally.
//  Invalid in_ctrl (MSBs!=11) at accept: treated as DIVU. No error flag.
// STRUCTURE
//  Shared include frag_alu_defs.vh: CTRL_DIV/DIVU/REM/REMU codes (same values as ALU control)
//   and FSM state encodings S_IDLE/S_CALC/S_FIX/S_DONE.
//  Sub-module frag_div_step: combinational one-bit restoring step (rem_in, q_in, divisor ->
//   rem_out, q_out), XLEN-parametrised. The FSM, counter, sign fixup and handshakes stay in
//   frag_div_unit.
// TESTING (XLEN=32)
//  DIV a=-7 (0xFFFFFFF9) b=2 -> out_data 0xFFFFFFFD after 33 cycles; REM same operands -> 0xFFFFFFFF.
//  DIVU a=0xFFFFFFFF b=16 -> 0x0FFFFFFF; REMU -> 0x0000000F. out_tag equals in_tag.
//  b=0, a=0x12345678: DIV -> 0xFFFFFFFF, REM -> 0x12345678; out_valid 1 cycle after accept.
//  DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. Repeat with FAST_SPECIAL=0: same values.
//  Hold out_ready=0 for 5 cycles at DONE: out_data/out_tag stable, in_ready=0. Second request
//   accepted only after retire.
//  flush at CALC cycle 10 -> IDLE next edge, no out_valid. rst_n pulse mid-CALC -> reset values,
//   and the following DIVU 100/7 -> 14.

Source files
------------

// File: rtl/frag_div_unit_pkg.sv
// frag_div_unit_pkg: control codes, FSM states and ctrl decode for the iterative divider.
package frag_div_unit_pkg;

   localparam logic [3:0] CTRL_DIV  = 4'b1100;
   localparam logic [3:0] CTRL_DIVU = 4'b1101;
   localparam logic [3:0] CTRL_REM  = 4'b1110;
   localparam logic [3:0] CTRL_REMU = 4'b1111;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

   // Returns {signed_op, rem_op}; codes outside the divide group behave as DIVU.
   function automatic logic [1:0] decode_ctrl(input logic [3:0] c);
      return (c[3:2] == 2'b11) ? {~c[0], c[1]} : 2'b00;
   endfunction

endpackage

// File: rtl/frag_div_step.sv
// frag_div_step: one restoring step, shifting the next dividend bit into the partial remainder.
module frag_div_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] div_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] sh, diff;

   always_comb begin
      sh    = {rem_i, quo_i[XLEN-1]};
      diff  = sh - {1'b0, div_i};
      rem_o = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], ~diff[XLEN]};
   end

endmodule

// File: rtl/frag_div_unit.sv
// frag_div_unit: multi-cycle restoring divider for DIV/DIVU/REM/REMU with valid/ready handshakes.
module frag_div_unit
   import frag_div_unit_pkg::*;
#(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned TAG_W        = 5,
   parameter int unsigned FAST_SPECIAL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_ctrl,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int unsigned    CNT_W   = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   state_e           state_q;
   logic [XLEN-1:0]  rem_q, quo_q, div_q, out_data_q;
   logic [XLEN-1:0]  rem_d, quo_d;
   logic [CNT_W-1:0] cnt_q;
   logic [TAG_W-1:0] tag_q;
   logic             is_rem_q, neg_q_q, neg_r_q, div0_q;

   logic             sgn, rem_op, a_neg, b_neg, b_zero, ovf, special;
   logic [XLEN-1:0]  abs_a, abs_b, spec_res, q_fix, r_fix;

   always_comb begin
      {sgn, rem_op} = decode_ctrl(in_ctrl);
      a_neg    = sgn & in_a[XLEN-1];
      b_neg    = sgn & in_b[XLEN-1];
      abs_a    = a_neg ? -in_a : in_a;
      abs_b    = b_neg ? -in_b : in_b;
      b_zero   = in_b == '0;
      ovf      = sgn & (in_a == MIN_INT) & (in_b == '1);
      special  = (b_zero | ovf) & (FAST_SPECIAL != 0);
      spec_res = b_zero ? (rem_op ? in_a : '1) : (rem_op ? '0 : MIN_INT);
      // Iterating on |a|/0 leaves |a| in the remainder, but the quotient must be forced to all ones.
      q_fix    = div0_q ? '1 : (neg_q_q ? -quo_q : quo_q);
      r_fix    = neg_r_q ? -rem_q : rem_q;
   end

   frag_div_step #(.XLEN(XLEN)) u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .div_i (div_q),
      .rem_o (rem_d),
      .quo_o (quo_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rem_q      <= '0;
         quo_q      <= '0;
         div_q      <= '0;
         cnt_q      <= '0;
         tag_q      <= '0;
         out_data_q <= '0;
         is_rem_q   <= 1'b0;
         neg_q_q    <= 1'b0;
         neg_r_q    <= 1'b0;
         div0_q     <= 1'b0;
      end else if (flush) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (in_valid) begin
               tag_q    <= in_tag;
               is_rem_q <= rem_op;
               neg_q_q  <= a_neg ^ b_neg;
               neg_r_q  <= a_neg;
               div0_q   <= b_zero;
               rem_q    <= '0;
               quo_q    <= abs_a;
               div_q    <= abs_b;
               cnt_q    <= CNT_W'(XLEN - 1);
               if (special) out_data_q <= spec_res;
               state_q  <= special ? S_DONE : S_CALC;
            end
            S_CALC: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) state_q <= S_FIX;
            end
            S_FIX: begin
               out_data_q <= is_rem_q ? r_fix : q_fix;
               state_q    <= S_DONE;
            end
            S_DONE: if (out_ready) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = state_q == S_IDLE;
   assign out_valid = state_q == S_DONE;
   assign busy      = state_q != S_IDLE;
   assign out_data  = out_data_q;
   assign out_tag   = tag_q;

endmodule
